// File: rtl/mono_ro_ctrl_if.sv
// mono_ro_ctrl_if: valid/ready word stream from the readout sequencer to the downstream FIFO
interface mono_ro_ctrl_if;
  logic [29:0] out_data;
  logic        out_valid;
  logic        out_ready;
  modport master(output out_data, out_valid, input out_ready);
  modport slave(input out_data, out_valid, output out_ready);
endinterface

// File: rtl/mono_ro_ctrl.sv
// mono_ro_ctrl: monopix readout sequencer (freeze, per-hit READ, 30-bit serial capture, nRST pulse)
module mono_ro_ctrl #(
  parameter int FREEZE_DLY = 2,
  parameter int READ_LEN   = 2,
  parameter int SER_LAT    = 4,
  parameter int TOK_SETTLE = 3,
  parameter int MAX_WORDS  = 256,
  parameter int NRST_LEN   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  rst_chip,
  input  logic                  Token_Out,
  input  logic                  Data_Out,
  output logic                  FREEZE,
  output logic                  READ,
  output logic                  nRST,
  output logic                  busy,
  output logic [15:0]           word_cnt,
  output logic                  overrun,
  mono_ro_ctrl_if.master        ro
);
  typedef enum logic [2:0] {IDLE, NRST, FRZ_WAIT, RD, SHIFT, PUSH, SETTLE} state_t;
  localparam logic [8:0] FRZ_END    = 9'(FREEZE_DLY - 1);
  localparam logic [8:0] NRST_END   = 9'(NRST_LEN - 1);
  localparam logic [8:0] RD_END     = 9'(READ_LEN);
  localparam logic [8:0] SMP_FIRST  = 9'(SER_LAT);
  localparam logic [8:0] SMP_LAST   = 9'(SER_LAT + 29);
  localparam logic [8:0] SETTLE_END = 9'(READ_LEN + TOK_SETTLE);
  localparam logic [8:0] WIN_MAX    = 9'(MAX_WORDS);
  state_t      state;
  logic [1:0]  tok_sync;
  logic        tok_s;
  logic [8:0]  cnt;
  logic [8:0]  e;
  logic [8:0]  cnt_inc;
  logic [8:0]  win_cnt;
  logic [29:0] sr;
  logic        sample_en;
  assign tok_s     = tok_sync[1];
  assign e         = cnt + 9'd1;
  assign cnt_inc   = (cnt == 9'h1fe) ? cnt : e;
  assign sample_en = (state == RD || state == SHIFT) && e >= SMP_FIRST && e <= SMP_LAST;
  // two-flop synchroniser for the chip token
  always_ff @(posedge clk or posedge rst)
    if (rst) tok_sync <= '0;
    else tok_sync <= {tok_sync[0], Token_Out};
  // sequencer: cnt is the edge index since READ rose (or the wait counter in NRST/FRZ_WAIT), saturating while stalled
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= IDLE;
      FREEZE       <= 1'b0;
      READ         <= 1'b0;
      nRST         <= 1'b1;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      word_cnt     <= '0;
      win_cnt      <= '0;
      cnt          <= '0;
      sr           <= '0;
      ro.out_data  <= '0;
      ro.out_valid <= 1'b0;
    end else begin
      cnt <= cnt_inc;
      if (sample_en) sr <= {sr[28:0], Data_Out};
      case (state)
        IDLE:
          if (rst_chip) begin
            state <= NRST;
            nRST  <= 1'b0;
            busy  <= 1'b1;
            cnt   <= '0;
          end else if (enable && tok_s) begin
            state   <= FRZ_WAIT;
            FREEZE  <= 1'b1;
            busy    <= 1'b1;
            cnt     <= '0;
            win_cnt <= '0;
          end
        NRST:
          if (cnt == NRST_END) begin
            state <= IDLE;
            nRST  <= 1'b1;
            busy  <= 1'b0;
          end
        FRZ_WAIT:
          if (cnt == FRZ_END) begin
            state <= RD;
            READ  <= 1'b1;
            cnt   <= '0;
          end
        RD:
          if (e == RD_END) begin
            state <= SHIFT;
            READ  <= 1'b0;
          end
        SHIFT:
          if (e == SMP_LAST) begin
            state        <= PUSH;
            ro.out_valid <= 1'b1;
            ro.out_data  <= {sr[28:0], Data_Out};
          end
        PUSH:
          if (ro.out_ready) begin
            state        <= SETTLE;
            ro.out_valid <= 1'b0;
            word_cnt     <= word_cnt + 16'd1;
            win_cnt      <= win_cnt + 9'd1;
          end
        SETTLE:
          if (e >= SETTLE_END) begin
            if (tok_s && win_cnt < WIN_MAX) begin
              state <= RD;
              READ  <= 1'b1;
              cnt   <= '0;
            end else begin
              state  <= IDLE;
              FREEZE <= 1'b0;
              busy   <= 1'b0;
              if (tok_s) overrun <= 1'b1;
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mono_ro_ctrl.sv
// tb_mono_ro_ctrl: randomized chip model plus scoreboard for the monopix readout sequencer
module tb_mono_ro_ctrl;
  localparam int SER_LAT = 4, READ_LEN = 2, TOK_SETTLE = 3, FREEZE_DLY = 2, NRST_LEN = 4, MAX_W = 4;
  localparam int SPACING = ((READ_LEN + TOK_SETTLE) > (SER_LAT + 30) ? (READ_LEN + TOK_SETTLE) : (SER_LAT + 30)) + 1;
  localparam logic [29:0] TP = 30'b100000_10101010_11001100_00001111;
  logic clk = 0, rst = 1, enable = 0, rst_chip = 0, Token_Out = 0, Data_Out = 0;
  logic FREEZE, READ, nRST, busy, overrun;
  logic [15:0] word_cnt;
  mono_ro_ctrl_if ro();
  mono_ro_ctrl #(.MAX_WORDS(MAX_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .rst_chip(rst_chip), .Token_Out(Token_Out), .Data_Out(Data_Out),
    .FREEZE(FREEZE), .READ(READ), .nRST(nRST), .busy(busy), .word_cnt(word_cnt), .overrun(overrun), .ro(ro.master)
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  logic [29:0] hitq[$], expq[$];
  logic [29:0] cur = '0, held = '0, ew;
  bit force_tok = 0, tp_mode = 0, exp_tp = 0, rnd_ready = 0, first_rd = 0, stall = 0;
  logic rd_prev = 0, m_rd = 0, m_fz = 0;
  int kk = 1000, cyc = 0, exp_wc = 0, tot = 0, n_reads = 0, n_fz_rise = 0, hs_cyc = 0, rise_cyc = 0, fz_cyc = 0;
  int nlow, frz_nrst, tp_base;
  bit ok;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] mk(input logic [7:0] le, input logic [7:0] te, input logic [7:0] row, input logic [5:0] col);
    return {le, te, row, col};
  endfunction

  task automatic add_hit(input logic [29:0] w);
    hitq.push_back(w);
    expq.push_back(w);
    tot++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int lim);
    bit done = 0;
    for (int i = 0; i < lim && !done; i++) begin
      tick();
      if (rnd_ready) ro.out_ready = 1'($urandom);
      done = expq.size() == 0 && hitq.size() == 0 && !busy && !ro.out_valid;
    end
    chk({tag, "_done"}, done, 1);
  endtask

  task automatic wait_read(input string tag, input int lim);
    bit done = 0;
    for (int i = 0; i < lim && !done; i++) begin
      tick();
      done = READ;
    end
    chk({tag, "_read_seen"}, done, 1);
  endtask

  // chip model: token high while hits are pending, word latched at READ rise, popped at READ fall, MSB at SER_LAT
  always @(negedge clk) begin
    if (READ && !rd_prev) begin
      kk = 0;
      cur = tp_mode ? TP : (hitq.size() > 0 ? hitq[0] : 30'd0);
    end else begin
      if (!READ && rd_prev && !tp_mode && hitq.size() > 0) hitq.delete(0);
      if (kk < 1000) kk++;
    end
    rd_prev = READ;
    Token_Out = force_tok || hitq.size() > 0;
    Data_Out = (kk + 1 >= SER_LAT && kk + 1 < SER_LAT + 30) ? cur[29 - (kk + 1 - SER_LAT)] : 1'($urandom);
  end

  always @(posedge clk) cyc++;

  // protocol monitor and scoreboard
  always @(negedge clk) begin
    if (rst) begin
      first_rd = 0;
      stall = 0;
    end else begin
      if (FREEZE && !m_fz) begin
        n_fz_rise++;
        fz_cyc = cyc;
        first_rd = 1;
      end
      if (!FREEZE && m_fz) chk("freeze_drop_latency", (cyc - hs_cyc) <= TOK_SETTLE + 1, 1);
      if (READ && !m_rd) begin
        n_reads++;
        chk("read_under_freeze", FREEZE, 1);
        if (first_rd) chk("freeze_to_read", cyc - fz_cyc, FREEZE_DLY);
        else chk("read_spacing_min", (cyc - rise_cyc) >= SPACING, 1);
        rise_cyc = cyc;
        first_rd = 0;
      end
      if (!READ && m_rd) chk("read_len", cyc - rise_cyc, READ_LEN);
      if (FREEZE || !nRST) chk("busy_active", busy, 1);
      if (FREEZE) chk("nrst_in_window", nRST, 1);
      if (stall) begin
        chk("stall_data_stable", ro.out_data, held);
        chk("stall_valid_held", ro.out_valid, 1);
        chk("stall_no_read", READ, 0);
      end
      stall = ro.out_valid && !ro.out_ready;
      held = ro.out_data;
      if (ro.out_valid && ro.out_ready) begin
        hs_cyc = cyc;
        exp_wc++;
        if (exp_tp) chk("test_pattern_word", ro.out_data, TP);
        else begin
          ew = 'x;
          if (expq.size() > 0) ew = expq.pop_front();
          chk("word", ro.out_data, ew);
        end
      end
    end
    m_rd = READ;
    m_fz = FREEZE;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ro.out_ready = 1;
    repeat (3) tick();
    chk("rst_FREEZE", FREEZE, 0);
    chk("rst_READ", READ, 0);
    chk("rst_nRST", nRST, 1);
    chk("rst_valid", ro.out_valid, 0);
    chk("rst_data", ro.out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_overrun", overrun, 0);
    rst = 0;
    repeat (2) tick();
    // single hit; rst_chip arrives together with enable and wins over the pending token
    n_reads = 0;
    add_hit(mk(8'h12, 8'h34, 8'd17, 6'd3));
    repeat (5) tick();
    chk("no_freeze_when_disabled", FREEZE, 0);
    enable = 1;
    rst_chip = 1;
    tick();
    rst_chip = 0;
    nlow = 0;
    frz_nrst = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!nRST) begin
        nlow++;
        if (FREEZE) frz_nrst++;
      end
    end
    chk("nrst_len", nlow, NRST_LEN);
    chk("freeze_during_nrst", frz_nrst, 0);
    wait_done("single", 300);
    chk("single_reads", n_reads, 1);
    chk("single_word_cnt", word_cnt, tot);
    chk("single_overrun", overrun, 0);
    // three hits in cols 0, 0, 35; enable dropped and rst_chip pulsed mid-window
    n_reads = 0;
    n_fz_rise = 0;
    for (int i = 0; i < 3; i++) add_hit(mk(8'($urandom), 8'($urandom), 8'($urandom), i == 2 ? 6'd35 : 6'd0));
    wait_read("multi", 100);
    enable = 0;
    rst_chip = 1;
    tick();
    rst_chip = 0;
    wait_done("multi", 500);
    enable = 1;
    chk("multi_reads", n_reads, 3);
    chk("multi_one_window", n_fz_rise, 1);
    chk("multi_word_cnt", word_cnt, tot);
    // backpressure on the second word
    n_reads = 0;
    for (int i = 0; i < 3; i++) add_hit(30'($urandom));
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick();
      ok = ro.out_valid && expq.size() == 2;
    end
    chk("bp_second_word_seen", ok, 1);
    ro.out_ready = 0;
    repeat (100) tick();
    chk("bp_reads_during_stall", n_reads, 2);
    chk("bp_valid_held", ro.out_valid, 1);
    chk("bp_word_cnt_stalled", word_cnt, tot - 2);
    ro.out_ready = 1;
    wait_done("bp", 400);
    chk("bp_reads", n_reads, 3);
    chk("bp_word_cnt", word_cnt, tot);
    // random bursts with random downstream readiness
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < int'($urandom_range(1, 3)); i++) add_hit(30'($urandom));
      rnd_ready = 1;
      wait_done("random", 1500);
      rnd_ready = 0;
      ro.out_ready = 1;
      chk("random_word_cnt", word_cnt, tot);
    end
    chk("no_overrun_yet", overrun, 0);
    // six hits with a four-word window limit
    n_reads = 0;
    n_fz_rise = 0;
    for (int i = 0; i < 6; i++) add_hit(30'($urandom));
    wait_done("overrun", 1000);
    chk("overrun_reads", n_reads, 6);
    chk("overrun_windows", n_fz_rise, 2);
    chk("overrun_flag", overrun, 1);
    chk("overrun_word_cnt", word_cnt, tot);
    // test pattern with the token forced high
    tp_base = exp_wc;
    tp_mode = 1;
    exp_tp = 1;
    force_tok = 1;
    ok = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      tick();
      ok = exp_wc >= tp_base + 5;
    end
    chk("tp_words_seen", ok, 1);
    force_tok = 0;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      ok = !busy;
    end
    chk("tp_window_closed", ok, 1);
    tp_mode = 0;
    exp_tp = 0;
    // asynchronous reset during SHIFT
    add_hit(30'($urandom));
    wait_read("midrst", 200);
    repeat (10) tick();
    rst = 1;
    expq.delete();
    tot = 0;
    #1;
    chk("midrst_READ", READ, 0);
    chk("midrst_FREEZE", FREEZE, 0);
    chk("midrst_valid", ro.out_valid, 0);
    chk("midrst_data", ro.out_data, 0);
    chk("midrst_word_cnt", word_cnt, 0);
    chk("midrst_overrun", overrun, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_nRST", nRST, 1);
    repeat (2) tick();
    rst = 0;
    repeat (5) tick();
    chk("midrst_idle", busy, 0);
    add_hit(mk(8'hA5, 8'h5A, 8'd200, 6'd47));
    wait_done("recover", 300);
    chk("recover_word_cnt", word_cnt, tot);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
